// File: rtl/bit_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_adder_pkg
// Description : Shared state encoding and sizing helper for the bit-serial
//               adder. Code 3 is unused and decodes back to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
package bit_serial_adder_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Bit counter width: enough to hold WIDTH-1, never narrower than 1 bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_serial_adder_adder.sv
`default_nettype none
// ============================================================================
// Module      : adder
// Description : 1-bit full adder used as the bit-slice of the serial adder.
// Ports       : a, b, cin - addend bits and carry-in
//               sum, cout - sum bit and carry-out
// Revision    : 1.0 - initial release
// ============================================================================
module adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/bit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_adder
// Description : Adds two WIDTH-bit operands one bit per clock, LSB first,
//               through a single 1-bit full adder. Start/busy/done handshake.
// Ports       : clk, rst_n        - clock, async active-low reset
//               start             - request, sampled only in IDLE
//               a_in, b_in, cin_in- operands, captured on accepted start
//               busy              - high while bits are processed
//               done              - one-cycle completion pulse
//               sum_out, cout_out - registered result, held until next done
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    localparam int                 c_CNT_W = cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_res_sr;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_count;
    logic               w_sum;
    logic               w_cout;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    // Current bit slice: LSBs of the operand shift registers plus the carry.
    adder u_adder (r_a_sr[0], r_b_sr[0], r_carry, w_sum, w_cout);

    assign w_last = (r_count == c_LAST);

    // Result shift register fills from the top, so after WIDTH shifts the
    // first (LSB) sum bit has arrived at bit 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            logic w_unused_res;
            assign w_unused_res = r_res_sr[0];
            assign w_res_next   = w_sum;
        end else begin : g_res_wn
            logic w_unused_res;
            assign w_unused_res = r_res_sr[0];
            assign w_res_next   = {w_sum, r_res_sr[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE:  w_next_state = start  ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: w_next_state = w_last ? ST_DONE  : ST_SHIFT;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, serial shifting, result registers.
    // sum_out/cout_out are deliberately not cleared on start so the last
    // result stays readable while the next operation runs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sr  <= a_in;
                        r_b_sr  <= b_in;
                        r_carry <= cin_in;
                        r_count <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_res_sr <= w_res_next;
                    r_carry  <= w_cout;
                    r_count  <= r_count + c_ONE;
                    if (w_last) begin
                        sum_out  <= w_res_next;
                        cout_out <= w_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
